coherence_bus_arbiter: RTL and testbench
========================================

// Module: coherence_bus_arbiter
// PURPOSE
//  Sole owner of the shared snoop bus and unified-memory port for NUM_CPU MSI cache controllers.
//  Arbitrates round-robin among cache requests, broadcasts snoops (search/invalidate) to non-owners,
//  and selects the line source for the owner: peer cache or unified memory.
//  Drives each controller's grant, u_rdy and datasel.
// PARAMETERS
//  NUM_CPU      2    number of cache controllers (requester index 0..NUM_CPU-1)
//  TIMEOUT      255  max cycles spent in MEM waiting for mem_rdy before abort
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            async active-low reset
//  rd_miss      in   NUM_CPU      per-CPU read-miss request (level, held until u_rdy)
//  wr_miss      in   NUM_CPU      per-CPU write-miss request
//  inv_req      in   NUM_CPU      per-CPU invalidate-others request (SHARED->MODIFIED upgrade)
//  mem_re_req   in   NUM_CPU      per-CPU plain unified-memory line read
//  mem_we_req   in   NUM_CPU      per-CPU eviction write of dirty line
//  req_addr     in   13*NUM_CPU   per-CPU word address (BICO)
//  evict_line   in   64*NUM_CPU   per-CPU line to write on eviction
//  snoop_found  in   NUM_CPU      peer hit on bus_addr (valid in SNOOP)
//  snoop_line   in   64*NUM_CPU   peer line for bus_addr
//  mem_rdy      in   1            unified memory done (read data valid / write accepted)
//  mem_rd_data  in   64           unified memory read line
//  grant        out  NUM_CPU      one-hot bus ownership
//  bus_addr     out  13           latched owner address (BOCI)
//  snoop_search out  NUM_CPU      search strobe to every non-owner
//  snoop_inv    out  NUM_CPU      invalidate strobe to every non-owner
//  cpu_datasel  out  2            00 = memory, 01 = peer cache; valid while grant
//  xfer_line    out  64           line to owner: peer line or mem_rd_data
//  u_rdy        out  NUM_CPU      owner completion strobe (1 cycle)
//  mem_re/mem_we out 1 each       unified memory strobes, held until mem_rdy
//  mem_addr     out  11           bus_addr[12:2]
//  mem_wr_data  out  64           latched owner evict_line
//  bus_err      out  1            1-cycle pulse on TIMEOUT abort
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, every output 0, cpu_datasel 00.
//  Request kind per CPU, priority: inv_req > wr_miss > rd_miss > mem_we_req > mem_re_req.
//  IDLE: any request present -> pick first requester at/after rr pointer (wrapping mod NUM_CPU).
//    Latch owner, kind, addr, evict_line; rr pointer = owner+1 mod NUM_CPU.
//    Next state: SNOOP for inv/wr_miss/rd_miss; MEM for mem_we/mem_re.
//  grant[owner] rises the cycle after selection and holds until the cycle after u_rdy.
//  SNOOP (exactly 1 cycle): snoop_search = ~grant; snoop_inv = ~grant for inv or wr_miss.
//    inv                         -> DONE
//    rd/wr_miss, any snoop_found -> cpu_datasel = 01, xfer_line = lowest-index found peer's line, DONE
//    otherwise                   -> cpu_datasel = 00, MEM with mem_re
//  MEM: mem_re or mem_we held, mem_addr = bus_addr[12:2], watchdog counts.
//    mem_rdy             -> xfer_line = mem_rd_data, DONE
//    count reaches TIMEOUT -> bus_err pulse, drop strobes, grant low, IDLE; no u_rdy
//  DONE: u_rdy[owner] = 1 for one cycle, xfer_line/cpu_datasel held; then IDLE.
//  Latency: miss served from peer = grant at T+1, u_rdy at T+2. Memory miss = u_rdy 1 cycle after mem_rdy.
//  Owner drops all request bits before u_rdy (SNOOP/MEM) -> abort to IDLE next cycle; strobes low, no u_rdy.
//  New requests arriving while busy are ignored until IDLE; requests are levels and are never lost.
//  Only one non-idle transaction at a time. snoop_* never asserted to the owner.
//  mem_re and mem_we never both high.
// TESTING
//  1. CPU0 rd_miss addr 0x0104, CPU1 snoop_found, snoop_line=64'hA5A5..
//     -> grant=01 @T+1, snoop_search=10, u_rdy[0] @T+2, datasel=01, xfer_line=A5A5..
//  2. CPU1 wr_miss addr 0x1FFC, no peer hit, mem_rdy after 3 cycles with 64'h1234..
//     -> snoop_inv=01, mem_re, mem_addr=0x7FF, u_rdy[1], datasel=00, xfer_line=1234..
//  3. Both CPUs rd_miss together, rr=0 -> CPU0 served first, then CPU1 back-to-back; rr ends at 0.
//  4. CPU0 mem_we_req with evict_line 64'hDEAD.. -> no snoop, mem_we held until mem_rdy, mem_wr_data=DEAD..
//  5. mem_rdy never arrives -> bus_err pulse after 255 MEM cycles, grant low, back to IDLE.
//  6. rst_n low during MEM -> all outputs 0 immediately; after release a pending inv_req is served
//     from CPU0 (rr=0).

Source files
------------

// File: rtl/coherence_bus_arbiter.sv
// Snoop-bus and unified-memory arbiter for NUM_CPU MSI cache controllers.
// Round-robin ownership, one transaction in flight, peer-or-memory line sourcing.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; pick next requester at/after rr pointer
// SNOOP | one cycle: search/invalidate broadcast to non-owners
// MEM   | unified-memory read or write strobe held, watchdog running
// DONE  | one cycle: u_rdy to owner, line and datasel held
module coherence_bus_arbiter #(
    parameter int NUM_CPU = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CPU-1:0]    rd_miss,
    input  logic [NUM_CPU-1:0]    wr_miss,
    input  logic [NUM_CPU-1:0]    inv_req,
    input  logic [NUM_CPU-1:0]    mem_re_req,
    input  logic [NUM_CPU-1:0]    mem_we_req,
    input  logic [13*NUM_CPU-1:0] req_addr,
    input  logic [64*NUM_CPU-1:0] evict_line,
    input  logic [NUM_CPU-1:0]    snoop_found,
    input  logic [64*NUM_CPU-1:0] snoop_line,
    input  logic                  mem_rdy,
    input  logic [63:0]           mem_rd_data,
    output logic [NUM_CPU-1:0]    grant,
    output logic [12:0]           bus_addr,
    output logic [NUM_CPU-1:0]    snoop_search,
    output logic [NUM_CPU-1:0]    snoop_inv,
    output logic [1:0]            cpu_datasel,
    output logic [63:0]           xfer_line,
    output logic [NUM_CPU-1:0]    u_rdy,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [10:0]           mem_addr,
    output logic [63:0]           mem_wr_data,
    output logic                  bus_err
);

    localparam int IW = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_MEM, S_DONE} state_t;
    typedef enum logic [2:0] {K_INV, K_WR, K_RD, K_MWE, K_MRE} kind_t;

    state_t          state, state_nx;
    kind_t           kind, kind_nx, pick_kind;
    logic [IW-1:0]   rr, rr_nx, owner, owner_nx, pick_idx;
    logic [12:0]     addr_q, addr_nx;
    logic [63:0]     evict_q, evict_nx, xfer_q, xfer_nx, peer_line;
    logic [1:0]      datasel_q, datasel_nx;
    logic [CW-1:0]   cnt_q, cnt_nx;
    logic            err_q, err_nx, pick_vld, peer_hit, owner_active;
    logic [NUM_CPU-1:0] any_req, owner_oh;

    assign any_req      = rd_miss | wr_miss | inv_req | mem_re_req | mem_we_req;
    assign owner_oh     = NUM_CPU'(1) << owner;
    assign owner_active = any_req[owner];

    // Round-robin search starting at the rr pointer, plus per-CPU request priority.
    always_comb begin
        int j;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            j = int'(rr) + i;
            if (j >= NUM_CPU) j = j - NUM_CPU;
            if (!pick_vld && any_req[j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
            end
        end
        if (inv_req[pick_idx])      pick_kind = K_INV;
        else if (wr_miss[pick_idx]) pick_kind = K_WR;
        else if (rd_miss[pick_idx]) pick_kind = K_RD;
        else if (mem_we_req[pick_idx]) pick_kind = K_MWE;
        else                        pick_kind = K_MRE;
    end

    // Lowest-index peer (never the owner) reporting a hit supplies the line.
    always_comb begin
        peer_hit  = 1'b0;
        peer_line = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (!peer_hit && snoop_found[i] && (IW'(i) != owner)) begin
                peer_hit  = 1'b1;
                peer_line = snoop_line[i*64 +: 64];
            end
        end
    end

    // State register and transaction context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            kind      <= K_INV;
            rr        <= '0;
            owner     <= '0;
            addr_q    <= '0;
            evict_q   <= '0;
            xfer_q    <= '0;
            datasel_q <= 2'b00;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            kind      <= kind_nx;
            rr        <= rr_nx;
            owner     <= owner_nx;
            addr_q    <= addr_nx;
            evict_q   <= evict_nx;
            xfer_q    <= xfer_nx;
            datasel_q <= datasel_nx;
            cnt_q     <= cnt_nx;
            err_q     <= err_nx;
        end
    end

    // Next-state logic; an owner that drops every request bit aborts the transaction.
    always_comb begin
        state_nx   = state;
        kind_nx    = kind;
        rr_nx      = rr;
        owner_nx   = owner;
        addr_nx    = addr_q;
        evict_nx   = evict_q;
        xfer_nx    = xfer_q;
        datasel_nx = datasel_q;
        cnt_nx     = cnt_q;
        err_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    owner_nx   = pick_idx;
                    kind_nx    = pick_kind;
                    addr_nx    = req_addr[int'(pick_idx)*13 +: 13];
                    evict_nx   = evict_line[int'(pick_idx)*64 +: 64];
                    rr_nx      = (int'(pick_idx) == NUM_CPU - 1) ? '0 : pick_idx + 1'b1;
                    datasel_nx = 2'b00;
                    if (pick_kind == K_MWE || pick_kind == K_MRE) begin
                        state_nx = S_MEM;
                        cnt_nx   = CW'(TIMEOUT - 1);
                    end else begin
                        state_nx = S_SNOOP;
                    end
                end
            end
            S_SNOOP: begin
                if (!owner_active) begin
                    state_nx = S_IDLE;
                end else if (kind == K_INV) begin
                    state_nx = S_DONE;
                end else if (peer_hit) begin
                    datasel_nx = 2'b01;
                    xfer_nx    = peer_line;
                    state_nx   = S_DONE;
                end else begin
                    datasel_nx = 2'b00;
                    cnt_nx     = CW'(TIMEOUT - 1);
                    state_nx   = S_MEM;
                end
            end
            S_MEM: begin
                if (!owner_active) begin
                    state_nx = S_IDLE;
                end else if (mem_rdy) begin
                    xfer_nx  = mem_rd_data;
                    state_nx = S_DONE;
                end else if (cnt_q == '0) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign grant        = (state != S_IDLE) ? owner_oh : '0;
    assign snoop_search = (state == S_SNOOP) ? ~owner_oh : '0;
    assign snoop_inv    = (state == S_SNOOP && (kind == K_INV || kind == K_WR)) ? ~owner_oh : '0;
    assign u_rdy        = (state == S_DONE) ? owner_oh : '0;
    assign mem_re       = (state == S_MEM) && (kind != K_MWE);
    assign mem_we       = (state == S_MEM) && (kind == K_MWE);
    assign bus_addr     = addr_q;
    assign mem_addr     = addr_q[12:2];
    assign mem_wr_data  = evict_q;
    assign cpu_datasel  = datasel_q;
    assign xfer_line    = xfer_q;
    assign bus_err      = err_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: selection vectors, directed corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_coherence_bus_arbiter;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  rd_miss, wr_miss, inv_req, mem_re_req, mem_we_req, snoop_found;
    logic [13*N-1:0] req_addr;
    logic [64*N-1:0] evict_line, snoop_line;
    logic          mem_rdy;
    logic [63:0]   mem_rd_data;
    logic [N-1:0]  grant, snoop_search, snoop_inv, u_rdy;
    logic [12:0]   bus_addr;
    logic [1:0]    cpu_datasel;
    logic [63:0]   xfer_line, mem_wr_data;
    logic          mem_re, mem_we, bus_err;
    logic [10:0]   mem_addr;

    int checks = 0;
    int failures = 0;
    int m_rr = 0;

    coherence_bus_arbiter #(.NUM_CPU(N), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .rd_miss(rd_miss), .wr_miss(wr_miss), .inv_req(inv_req),
        .mem_re_req(mem_re_req), .mem_we_req(mem_we_req), .req_addr(req_addr),
        .evict_line(evict_line), .snoop_found(snoop_found), .snoop_line(snoop_line),
        .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data), .grant(grant), .bus_addr(bus_addr),
        .snoop_search(snoop_search), .snoop_inv(snoop_inv), .cpu_datasel(cpu_datasel),
        .xfer_line(xfer_line), .u_rdy(u_rdy), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] rd, wr, inv, mre, mwe;
        logic [N-1:0] e_grant, e_search, e_inv;
        logic e_re, e_we;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs_packed();
        return {27'd0, grant, bus_addr, snoop_search, snoop_inv, cpu_datasel, u_rdy,
                mem_re, mem_we, mem_addr, bus_err};
    endfunction

    task automatic clear_inputs();
        rd_miss = '0; wr_miss = '0; inv_req = '0; mem_re_req = '0; mem_we_req = '0;
        snoop_found = '0; req_addr = '0; evict_line = '0; snoop_line = '0;
        mem_rdy = 1'b0; mem_rd_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_rr = 0;
        chk("reset_outputs", outs_packed(), 64'd0);
        chk("reset_xfer", xfer_line, 64'd0);
    endtask

    // Highest-priority request kind of a CPU: 0 inv, 1 wr, 2 rd, 3 mem_we, 4 mem_re.
    function automatic int kind_of(int c);
        if (inv_req[c])    return 0;
        if (wr_miss[c])    return 1;
        if (rd_miss[c])    return 2;
        if (mem_we_req[c]) return 3;
        return 4;
    endfunction

    function automatic logic pending(int c);
        return rd_miss[c] | wr_miss[c] | inv_req[c] | mem_re_req[c] | mem_we_req[c];
    endfunction

    task automatic new_req(input int c);
        logic [4:0] b;
        b = 5'($urandom_range(1, 31));
        inv_req[c] = b[0]; wr_miss[c] = b[1]; rd_miss[c] = b[2];
        mem_we_req[c] = b[3]; mem_re_req[c] = b[4];
        req_addr[c*13 +: 13] = 13'($urandom);
        evict_line[c*64 +: 64] = {$urandom, $urandom};
    endtask

    task automatic drop_req(input int c);
        inv_req[c] = 1'b0; wr_miss[c] = 1'b0; rd_miss[c] = 1'b0;
        mem_we_req[c] = 1'b0; mem_re_req[c] = 1'b0;
    endtask

    // Memory phase seen from the bench: strobe held for d+1 cycles, then mem_rdy.
    task automatic mem_phase(input int d, input logic we, input logic [12:0] a,
                             input logic [63:0] wd, output logic [63:0] rdata);
        rdata = {$urandom, $urandom};
        for (int m = 0; m <= d; m++) begin
            chk("mem_re_held", {63'd0, mem_re}, {63'd0, ~we});
            chk("mem_we_held", {63'd0, mem_we}, {63'd0, we});
            chk("mem_addr", {53'd0, mem_addr}, {53'd0, a[12:2]});
            if (we) chk("mem_wr_data", mem_wr_data, wd);
            if (m == d) begin
                mem_rdy = 1'b1;
                mem_rd_data = rdata;
            end
            tick();
        end
        mem_rdy = 1'b0;
    endtask

    initial begin
        int hi_cnt, owner, k, peer, d;
        logic seen_err, seen_urdy;
        logic [N-1:0] oh;
        logic [12:0] ea;
        logic [63:0] rdata, l0, l1;

        clear_inputs();

        // Selection vectors, each from reset (rr = 0); owner then drops -> abort, no u_rdy.
        vt[0] = '{rd:2'b01, wr:2'b00, inv:2'b00, mre:2'b00, mwe:2'b00, e_grant:2'b01, e_search:2'b10, e_inv:2'b00, e_re:0, e_we:0};
        vt[1] = '{rd:2'b00, wr:2'b10, inv:2'b00, mre:2'b00, mwe:2'b00, e_grant:2'b10, e_search:2'b01, e_inv:2'b01, e_re:0, e_we:0};
        vt[2] = '{rd:2'b01, wr:2'b00, inv:2'b01, mre:2'b00, mwe:2'b00, e_grant:2'b01, e_search:2'b10, e_inv:2'b10, e_re:0, e_we:0};
        vt[3] = '{rd:2'b00, wr:2'b00, inv:2'b00, mre:2'b01, mwe:2'b01, e_grant:2'b01, e_search:2'b00, e_inv:2'b00, e_re:0, e_we:1};
        vt[4] = '{rd:2'b00, wr:2'b00, inv:2'b00, mre:2'b10, mwe:2'b00, e_grant:2'b10, e_search:2'b00, e_inv:2'b00, e_re:1, e_we:0};
        vt[5] = '{rd:2'b10, wr:2'b00, inv:2'b00, mre:2'b00, mwe:2'b01, e_grant:2'b01, e_search:2'b00, e_inv:2'b00, e_re:0, e_we:1};
        vt[6] = '{rd:2'b01, wr:2'b01, inv:2'b00, mre:2'b01, mwe:2'b00, e_grant:2'b01, e_search:2'b10, e_inv:2'b10, e_re:0, e_we:0};
        vt[7] = '{rd:2'b00, wr:2'b00, inv:2'b00, mre:2'b11, mwe:2'b00, e_grant:2'b01, e_search:2'b00, e_inv:2'b00, e_re:1, e_we:0};
        for (int v = 0; v < 8; v++) begin
            do_reset();
            rd_miss = vt[v].rd; wr_miss = vt[v].wr; inv_req = vt[v].inv;
            mem_re_req = vt[v].mre; mem_we_req = vt[v].mwe;
            tick();
            chk($sformatf("vec%0d_grant", v), {62'd0, grant}, {62'd0, vt[v].e_grant});
            chk($sformatf("vec%0d_search", v), {62'd0, snoop_search}, {62'd0, vt[v].e_search});
            chk($sformatf("vec%0d_inv", v), {62'd0, snoop_inv}, {62'd0, vt[v].e_inv});
            chk($sformatf("vec%0d_re", v), {63'd0, mem_re}, {63'd0, vt[v].e_re});
            chk($sformatf("vec%0d_we", v), {63'd0, mem_we}, {63'd0, vt[v].e_we});
            clear_inputs();
            tick();
            chk($sformatf("vec%0d_abort", v), outs_packed() & 64'h1F_FFFF_FFFF & ~64'hF_FFF0_0000, 64'd0);
            chk($sformatf("vec%0d_abort_grant", v), {62'd0, grant}, 64'd0);
            tick();
            chk($sformatf("vec%0d_no_urdy", v), {62'd0, u_rdy}, 64'd0);
        end

        // Peer-served read miss.
        do_reset();
        rd_miss = 2'b01; req_addr[12:0] = 13'h0104;
        snoop_found = 2'b10; snoop_line[127:64] = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        chk("t1_grant", {62'd0, grant}, 64'h1);
        chk("t1_search", {62'd0, snoop_search}, 64'h2);
        chk("t1_inv", {62'd0, snoop_inv}, 64'h0);
        chk("t1_bus_addr", {51'd0, bus_addr}, 64'h0104);
        tick();
        chk("t1_urdy", {62'd0, u_rdy}, 64'h1);
        chk("t1_datasel", {62'd0, cpu_datasel}, 64'h1);
        chk("t1_xfer", xfer_line, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("t1_grant_held", {62'd0, grant}, 64'h1);
        clear_inputs();
        tick();
        chk("t1_release", {62'd0, grant | u_rdy}, 64'h0);

        // Write miss with no peer hit goes to memory.
        wr_miss = 2'b10; req_addr[25:13] = 13'h1FFC;
        tick();
        chk("t2_grant", {62'd0, grant}, 64'h2);
        chk("t2_inv", {62'd0, snoop_inv}, 64'h1);
        chk("t2_search", {62'd0, snoop_search}, 64'h1);
        tick();
        chk("t2_mem_addr", {53'd0, mem_addr}, 64'h7FF);
        mem_phase(2, 1'b0, 13'h1FFC, 64'd0, rdata);
        chk("t2_urdy", {62'd0, u_rdy}, 64'h2);
        chk("t2_datasel", {62'd0, cpu_datasel}, 64'h0);
        chk("t2_xfer", xfer_line, rdata);
        chk("t2_strobes_low", {62'd0, mem_re, mem_we}, 64'h0);
        clear_inputs();
        tick();

        // Simultaneous misses: CPU0 then CPU1 back-to-back; owner's own hit ignored.
        do_reset();
        l0 = 64'h0000_1111_2222_3333; l1 = 64'h4444_5555_6666_7777;
        rd_miss = 2'b11; snoop_found = 2'b11; snoop_line = {l1, l0};
        tick();
        chk("t3_grant0", {62'd0, grant}, 64'h1);
        tick();
        chk("t3_urdy0", {62'd0, u_rdy}, 64'h1);
        chk("t3_xfer0", xfer_line, l1);
        rd_miss[0] = 1'b0;
        tick();
        chk("t3_gap", {62'd0, grant}, 64'h0);
        tick();
        chk("t3_grant1", {62'd0, grant}, 64'h2);
        chk("t3_search1", {62'd0, snoop_search}, 64'h1);
        tick();
        chk("t3_urdy1", {62'd0, u_rdy}, 64'h2);
        chk("t3_xfer1", xfer_line, l0);
        rd_miss = 2'b00;
        tick();
        rd_miss = 2'b11;
        tick();
        chk("t3_rr_wrapped", {62'd0, grant}, 64'h1);
        clear_inputs();
        tick();

        // Eviction write: no snoop, mem_we held until mem_rdy.
        do_reset();
        mem_we_req = 2'b01; req_addr[12:0] = 13'h0AB4;
        evict_line[63:0] = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        chk("t4_grant", {62'd0, grant}, 64'h1);
        chk("t4_no_snoop", {60'd0, snoop_search, snoop_inv}, 64'h0);
        mem_phase(3, 1'b1, 13'h0AB4, 64'hDEAD_BEEF_DEAD_BEEF, rdata);
        chk("t4_urdy", {62'd0, u_rdy}, 64'h1);
        chk("t4_we_low", {63'd0, mem_we}, 64'h0);
        clear_inputs();
        tick();

        // Memory never answers: watchdog abort.
        do_reset();
        mem_re_req = 2'b10;
        tick();
        hi_cnt = 0; seen_err = 1'b0; seen_urdy = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus_err) begin
                seen_err = 1'b1;
                break;
            end
            if (mem_re) hi_cnt++;
            if (u_rdy != '0) seen_urdy = 1'b1;
            tick();
        end
        chk("t5_bus_err", {63'd0, seen_err}, 64'h1);
        chk("t5_mem_cycles", 64'(hi_cnt), 64'd255);
        chk("t5_no_urdy", {63'd0, seen_urdy}, 64'h0);
        chk("t5_grant_low", {62'd0, grant}, 64'h0);
        chk("t5_re_low", {63'd0, mem_re}, 64'h0);
        clear_inputs();
        tick();
        chk("t5_err_pulse", {63'd0, bus_err}, 64'h0);

        // Reset during MEM, then pending invalidates served from CPU0.
        do_reset();
        mem_re_req = 2'b01;
        tick();
        inv_req = 2'b11;
        tick();
        chk("t6_in_mem", {63'd0, mem_re}, 64'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_reset", outs_packed(), 64'd0);
        mem_re_req = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_rr = 0;
        tick();
        chk("t6_grant", {62'd0, grant}, 64'h1);
        chk("t6_inv", {62'd0, snoop_inv}, 64'h2);
        tick();
        chk("t6_urdy", {62'd0, u_rdy}, 64'h1);
        clear_inputs();
        tick();

        // Randomized transactions against a transaction-level model.
        do_reset();
        new_req($urandom_range(0, N - 1));
        if ($urandom_range(0, 1) == 1) new_req($urandom_range(0, N - 1));
        for (int t = 0; t < 60; t++) begin
            owner = -1;
            for (int i = 0; i < N; i++) begin
                if (owner < 0 && pending((m_rr + i) % N)) owner = (m_rr + i) % N;
            end
            m_rr = (owner + 1) % N;
            k = kind_of(owner);
            oh = N'(1) << owner;
            ea = req_addr[owner*13 +: 13];
            snoop_found = N'($urandom);
            snoop_line = {$urandom, $urandom, $urandom, $urandom};
            peer = -1;
            for (int i = 0; i < N; i++) if (peer < 0 && i != owner && snoop_found[i]) peer = i;
            d = $urandom_range(0, 4);
            tick();
            chk("rnd_grant", {62'd0, grant}, {62'd0, oh});
            chk("rnd_bus_addr", {51'd0, bus_addr}, {51'd0, ea});
            if (k <= 2) begin
                chk("rnd_search", {62'd0, snoop_search}, {62'd0, ~oh});
                chk("rnd_inv", {62'd0, snoop_inv}, (k <= 1) ? {62'd0, ~oh} : 64'd0);
                tick();
                if (k == 0) begin
                    chk("rnd_urdy_inv", {62'd0, u_rdy}, {62'd0, oh});
                end else if (peer >= 0) begin
                    chk("rnd_urdy_peer", {62'd0, u_rdy}, {62'd0, oh});
                    chk("rnd_datasel_peer", {62'd0, cpu_datasel}, 64'h1);
                    chk("rnd_xfer_peer", xfer_line, snoop_line[peer*64 +: 64]);
                end else begin
                    mem_phase(d, 1'b0, ea, 64'd0, rdata);
                    chk("rnd_urdy_mem", {62'd0, u_rdy}, {62'd0, oh});
                    chk("rnd_datasel_mem", {62'd0, cpu_datasel}, 64'h0);
                    chk("rnd_xfer_mem", xfer_line, rdata);
                end
            end else begin
                chk("rnd_no_snoop", {60'd0, snoop_search, snoop_inv}, 64'h0);
                mem_phase(d, k == 3, ea, evict_line[owner*64 +: 64], rdata);
                chk("rnd_urdy_memop", {62'd0, u_rdy}, {62'd0, oh});
                chk("rnd_datasel_memop", {62'd0, cpu_datasel}, 64'h0);
                if (k == 4) chk("rnd_xfer_memop", xfer_line, rdata);
            end
            drop_req(owner);
            for (int i = 0; i < N; i++) if (!pending(i) && $urandom_range(0, 1) == 1) new_req(i);
            if (!(pending(0) || pending(1))) new_req($urandom_range(0, N - 1));
            tick();
            chk("rnd_idle", {60'd0, grant, u_rdy}, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
